// File: rtl/card_deal_ctrl.sv
// card_deal_ctrl: pulls cards over valid/ready into 9 player and 9 dealer slots, with per-hand counts, ace-aware sums and bust flags
module card_deal_ctrl #(
    parameter int SLOTS  = 9,
    parameter int CODE_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    new_round,
    input  logic                    player_hit,
    input  logic                    dealer_hit,
    input  logic                    card_valid,
    input  logic [CODE_W-1:0]       card_code,
    output logic                    card_ready,
    output logic [SLOTS*CODE_W-1:0] player_cards,
    output logic [SLOTS*CODE_W-1:0] dealer_cards,
    output logic [3:0]              player_count,
    output logic [3:0]              dealer_count,
    output logic [5:0]              player_sum,
    output logic [5:0]              dealer_sum,
    output logic                    player_bust,
    output logic                    dealer_bust,
    output logic                    busy,
    output logic                    deal_done
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, STORE, TURN} state_t;
    state_t                  state_q, state_d;
    logic                    tgt_q, tgt_d;
    logic                    init_q, init_d;
    logic [1:0]              init_cnt_q, init_cnt_d;
    logic [SLOTS*CODE_W-1:0] p_cards_q, p_cards_d, d_cards_q, d_cards_d;
    logic [3:0]              p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    logic [5:0]              p_sum_q, p_sum_d, d_sum_q, d_sum_d;
    logic                    p_bust_q, p_bust_d, d_bust_q, d_bust_d;
    logic                    done_q, done_d;
    logic                    code_ok, p_open, d_open;
    logic [6:0]              p_best, d_best;
    function automatic logic [6:0] best_of(input logic [SLOTS*CODE_W-1:0] cards);
        logic [6:0] hard;
        logic       ace;
        logic [3:0] r;
        hard = '0;
        ace  = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            r    = cards[i*CODE_W +: 4];
            hard = hard + ((r > 4'd9) ? 7'd10 : {3'd0, r});
            ace  = ace | (r == 4'd1);
        end
        return (ace && hard <= 7'd11) ? hard + 7'd10 : hard;
    endfunction
    assign code_ok = card_code[3:0] != 4'd0 && card_code[3:0] <= 4'd13;
    assign p_open  = p_cnt_q != 4'(SLOTS) && !p_bust_q;
    assign d_open  = d_cnt_q != 4'(SLOTS) && !d_bust_q;
    assign p_best  = best_of(p_cards_q);
    assign d_best  = best_of(d_cards_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            init_q     <= 1'b0;
            init_cnt_q <= '0;
            p_cards_q  <= '0;
            d_cards_q  <= '0;
            p_cnt_q    <= '0;
            d_cnt_q    <= '0;
            p_sum_q    <= '0;
            d_sum_q    <= '0;
            p_bust_q   <= 1'b0;
            d_bust_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            init_q     <= init_d;
            init_cnt_q <= init_cnt_d;
            p_cards_q  <= p_cards_d;
            d_cards_q  <= d_cards_d;
            p_cnt_q    <= p_cnt_d;
            d_cnt_q    <= d_cnt_d;
            p_sum_q    <= p_sum_d;
            d_sum_q    <= d_sum_d;
            p_bust_q   <= p_bust_d;
            d_bust_q   <= d_bust_d;
            done_q     <= done_d;
        end
    end
    // The card is written on the transfer edge so the slot is visible in STORE;
    // STORE then scores the updated hand, and TURN only exists between initial-deal passes.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        init_d     = init_q;
        init_cnt_d = init_cnt_q;
        p_cards_d  = p_cards_q;
        d_cards_d  = d_cards_q;
        p_cnt_d    = p_cnt_q;
        d_cnt_d    = d_cnt_q;
        p_sum_d    = p_sum_q;
        d_sum_d    = d_sum_q;
        p_bust_d   = p_bust_q;
        d_bust_d   = d_bust_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                init_d = new_round;
                tgt_d  = !new_round && !player_hit;
                if (new_round) state_d = CLEAR;
                else if (player_hit ? p_open : dealer_hit && d_open) state_d = FETCH;
            end
            CLEAR: begin
                p_cards_d  = '0;
                d_cards_d  = '0;
                p_cnt_d    = '0;
                d_cnt_d    = '0;
                p_sum_d    = '0;
                d_sum_d    = '0;
                p_bust_d   = 1'b0;
                d_bust_d   = 1'b0;
                init_cnt_d = '0;
                tgt_d      = 1'b0;
                state_d    = FETCH;
            end
            FETCH: begin
                // Codes with an illegal rank are accepted and dropped; FETCH keeps asking.
                if (card_valid && code_ok) begin
                    if (tgt_q) begin
                        d_cards_d[int'(d_cnt_q)*CODE_W +: CODE_W] = card_code;
                        d_cnt_d = d_cnt_q + 4'd1;
                    end else begin
                        p_cards_d[int'(p_cnt_q)*CODE_W +: CODE_W] = card_code;
                        p_cnt_d = p_cnt_q + 4'd1;
                    end
                    state_d = STORE;
                end
            end
            STORE: begin
                if (tgt_q) begin
                    d_sum_d  = d_best > 7'd63 ? 6'd63 : d_best[5:0];
                    d_bust_d = d_best > 7'd21;
                end else begin
                    p_sum_d  = p_best > 7'd63 ? 6'd63 : p_best[5:0];
                    p_bust_d = p_best > 7'd21;
                end
                if (init_q && init_cnt_q != 2'd3) state_d = TURN;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            TURN: begin
                init_cnt_d = init_cnt_q + 2'd1;
                tgt_d      = !tgt_q;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        card_ready   = state_q == FETCH;
        busy         = state_q != IDLE;
        deal_done    = done_q;
        player_cards = p_cards_q;
        dealer_cards = d_cards_q;
        player_count = p_cnt_q;
        dealer_count = d_cnt_q;
        player_sum   = p_sum_q;
        dealer_sum   = d_sum_q;
        player_bust  = p_bust_q;
        dealer_bust  = d_bust_q;
    end
endmodule

// File: tb/tb_card_deal_ctrl.sv
// tb_card_deal_ctrl: scoreboard bench for card_deal_ctrl with directed deals and hand-computed hand values
module tb_card_deal_ctrl;
    localparam int SLOTS  = 9;
    localparam int CODE_W = 6;
    localparam int W      = SLOTS * CODE_W;
    logic         clk = 1'b0, rst = 1'b1;
    logic         new_round = 1'b0, player_hit = 1'b0, dealer_hit = 1'b0, card_valid = 1'b0;
    logic [5:0]   card_code = '0;
    logic         card_ready, busy, deal_done, player_bust, dealer_bust;
    logic [W-1:0] player_cards, dealer_cards;
    logic [3:0]   player_count, dealer_count;
    logic [5:0]   player_sum, dealer_sum;
    int           checks = 0, failures = 0, cyc = 0;
    typedef struct {
        logic [W-1:0] pc, dc;
        logic [3:0]   pn, dn;
        logic [5:0]   ps, ds;
        logic         pb, db;
        int           at;
    } exp_t;
    exp_t         sb[$];
    exp_t         got;
    logic [5:0]   deck[$];
    bit           valid_en = 1'b0, took = 1'b0;
    logic [5:0]   mp[SLOTS], md[SLOTS];
    int           np = 0, nd = 0;
    logic [5:0]   cur_ps = '0, cur_ds = '0;
    logic         cur_pb = 1'b0, cur_db = 1'b0;
    card_deal_ctrl #(.SLOTS(SLOTS), .CODE_W(CODE_W)) dut (
        .clk(clk), .rst(rst), .new_round(new_round), .player_hit(player_hit), .dealer_hit(dealer_hit),
        .card_valid(card_valid), .card_code(card_code), .card_ready(card_ready),
        .player_cards(player_cards), .dealer_cards(dealer_cards),
        .player_count(player_count), .dealer_count(dealer_count),
        .player_sum(player_sum), .dealer_sum(dealer_sum),
        .player_bust(player_bust), .dealer_bust(dealer_bust), .busy(busy), .deal_done(deal_done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic logic [W-1:0] pack(input logic [5:0] a[SLOTS]);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < SLOTS; i++) r[i*CODE_W +: CODE_W] = a[i];
        return r;
    endfunction
    // Deck source: offers deck[0] whenever enabled, pops after a completed handshake.
    always @(negedge clk) begin
        #1;
        if (took && deck.size() > 0) void'(deck.pop_front());
        card_valid = valid_en && deck.size() > 0;
        card_code  = card_valid ? deck[0] : 6'd0;
        took       = card_valid && card_ready;
    end
    always @(negedge clk) begin
        if (!rst && deal_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_deal_done: got deal_done=1 expected none (cycle %0d)", cyc);
            end else begin
                got = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(got.at));
                chk("player_cards", 64'(player_cards), 64'(got.pc));
                chk("dealer_cards", 64'(dealer_cards), 64'(got.dc));
                chk("player_count", 64'(player_count), 64'(got.pn));
                chk("dealer_count", 64'(dealer_count), 64'(got.dn));
                chk("player_sum", 64'(player_sum), 64'(got.ps));
                chk("dealer_sum", 64'(dealer_sum), 64'(got.ds));
                chk("player_bust", 64'(player_bust), 64'(got.pb));
                chk("dealer_bust", 64'(dealer_bust), 64'(got.db));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end
    task automatic zero_chk(input string name);
        chk({name, "_ready"}, 64'(card_ready), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(deal_done), 64'd0);
        chk({name, "_pcards"}, 64'(player_cards), 64'd0);
        chk({name, "_dcards"}, 64'(dealer_cards), 64'd0);
        chk({name, "_pcount"}, 64'(player_count), 64'd0);
        chk({name, "_dcount"}, 64'(dealer_count), 64'd0);
        chk({name, "_psum"}, 64'(player_sum), 64'd0);
        chk({name, "_dsum"}, 64'(dealer_sum), 64'd0);
        chk({name, "_pbust"}, 64'(player_bust), 64'd0);
        chk({name, "_dbust"}, 64'(dealer_bust), 64'd0);
    endtask
    task automatic pulse(input bit nr, input bit ph, input bit dh, output int t);
        @(negedge clk);
        new_round  = nr;
        player_hit = ph;
        dealer_hit = dh;
        t = cyc;
        @(negedge clk);
        new_round  = 1'b0;
        player_hit = 1'b0;
        dealer_hit = 1'b0;
    endtask
    task automatic push_exp(input int at);
        exp_t e;
        e.pc = pack(mp);
        e.dc = pack(md);
        e.pn = 4'(np);
        e.dn = 4'(nd);
        e.ps = cur_ps;
        e.ds = cur_ds;
        e.pb = cur_pb;
        e.db = cur_db;
        e.at = at;
        sb.push_back(e);
    endtask
    task automatic round(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d,
                         input logic [5:0] ps, input logic [5:0] ds, input bit with_hit);
        int t;
        deck.push_back(a);
        deck.push_back(b);
        deck.push_back(c);
        deck.push_back(d);
        for (int i = 0; i < SLOTS; i++) begin
            mp[i] = '0;
            md[i] = '0;
        end
        mp[0] = a; md[0] = b; mp[1] = c; md[1] = d;
        np = 2; nd = 2;
        cur_ps = ps; cur_ds = ds; cur_pb = 1'b0; cur_db = 1'b0;
        pulse(1'b1, with_hit, 1'b0, t);
        push_exp(t + 13);
    endtask
    task automatic hit(input bit dlr, input logic [5:0] c, input logic [5:0] s, input bit b, input int lat);
        int t;
        if (dlr) begin
            md[nd] = c; nd++; cur_ds = s; cur_db = b;
        end else begin
            mp[np] = c; np++; cur_ps = s; cur_pb = b;
        end
        pulse(1'b0, !dlr, dlr, t);
        push_exp(t + lat);
    endtask
    task automatic wait_done(input string name);
        int n = 0;
        while (!deal_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!deal_done) begin
            checks++;
            failures++;
            $display("FAIL %s: got no deal_done expected one within 60 cycles", name);
        end
    endtask
    task automatic ignored(input bit dlr, input string name);
        int t;
        pulse(1'b0, !dlr, dlr, t);
        for (int i = 0; i < 3; i++) begin
            chk({name, "_ready"}, 64'(card_ready), 64'd0);
            chk({name, "_busy"}, 64'(busy), 64'd0);
            @(negedge clk);
        end
    endtask
    initial begin
        int t;
        repeat (2) @(negedge clk);
        zero_chk("reset");
        rst = 1'b0;
        // Reset while a card is being offered in FETCH: nothing may be stored.
        pulse(1'b0, 1'b1, 1'b0, t);
        chk("fetch_ready", 64'(card_ready), 64'd1);
        chk("fetch_busy", 64'(busy), 64'd1);
        deck.push_back(6'h07);
        valid_en = 1'b1;
        #2 rst = 1'b1;
        #1 chk("async_ready_drop", 64'(card_ready), 64'd0);
        @(negedge clk);
        deck.delete();
        took = 1'b0;
        valid_en = 1'b0;
        zero_chk("midreset");
        rst = 1'b0;
        // Initial deal A, K, 5, 9 with card_valid held high.
        valid_en = 1'b1;
        round(6'h01, 6'h1D, 6'h05, 6'h09, 6'd16, 6'd19, 1'b0);
        @(negedge clk);
        chk("round_first_fetch", 64'(card_ready), 64'd1);
        @(negedge clk);
        chk("round_store_ready", 64'(card_ready), 64'd0);
        chk("round_store_pcount", 64'(player_count), 64'd1);
        chk("round_store_slot0", 64'(player_cards), 64'h01);
        wait_done("round1");
        // Soft aces collapsing to hard, then a bust.
        round(6'h01, 6'h02, 6'h11, 6'h03, 6'd12, 6'd5, 1'b0);
        wait_done("round2");
        deck.push_back(6'h09);
        hit(1'b0, 6'h09, 6'd21, 1'b0, 3);
        wait_done("hit_9");
        deck.push_back(6'h05);
        hit(1'b0, 6'h05, 6'd16, 1'b0, 3);
        wait_done("hit_5");
        deck.push_back(6'h0D);
        hit(1'b0, 6'h0D, 6'd26, 1'b1, 3);
        wait_done("hit_k");
        ignored(1'b0, "busted_hit");
        chk("busted_pcount", 64'(player_count), 64'd5);
        // Stalled deck plus an illegal code that must be discarded.
        round(6'h04, 6'h06, 6'h02, 6'h08, 6'd6, 6'd14, 1'b0);
        wait_done("round3");
        valid_en = 1'b0;
        deck.push_back(6'h0E);
        deck.push_back(6'h03);
        hit(1'b0, 6'h03, 6'd9, 1'b0, 14);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_busy", 64'(busy), 64'd1);
            chk("stall_ready", 64'(card_ready), 64'd1);
            chk("stall_pcount", 64'(player_count), 64'd2);
        end
        @(negedge clk);
        valid_en = 1'b1;
        wait_done("stall_hit");
        // new_round wins over a simultaneous hit; a hit while busy is dropped.
        round(6'h0A, 6'h07, 6'h0C, 6'h01, 6'd20, 6'd18, 1'b1);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0, t);
        wait_done("round4");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_queued_ready", 64'(card_ready), 64'd0);
            chk("no_queued_busy", 64'(busy), 64'd0);
        end
        // Dealer fills all nine slots with 2s, then a tenth hit is ignored.
        round(6'h0A, 6'h02, 6'h0A, 6'h12, 6'd20, 6'd4, 1'b0);
        wait_done("round5");
        for (int k = 0; k < 7; k++) begin
            logic [5:0] c;
            c = {2'(k % 4), 4'd2};
            deck.push_back(c);
            hit(1'b1, c, 6'(6 + 2 * k), 1'b0, 3);
            wait_done("dealer_fill");
        end
        ignored(1'b1, "full_hit");
        chk("full_dcount", 64'(dealer_count), 64'd9);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
